ga_run_controller: RTL and testbench

- Sequences one morphologic GA run per received 64-bit serial package.
- Pops an {origin, objetive} package from the serial RX queue, holds the GA in reset for a fixed window, then releases it.
- Counts generations, stops on zero error or on a generation limit, and hands a result word to the serial TX packager.
- Sits between the SerialRXPackage/SerialTXPackage pair and MorphologicGeneticAlgorithm in the debug top level.

---
 rtl/ga_ctrl_pkg.sv | 35 +++
 rtl/rising_edge_detect.sv | 21 ++
 rtl/ga_run_controller.sv | 218 +++++++++++++++++++++
 tb/tb_ga_run_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_ctrl_pkg.sv
// Shared state encoding and serial package field layout for the GA run controller.
package ga_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GARST,
    RUN,
    REPORT,
    WAIT_ACK,
    WAIT_TX
  } ga_state_e;

  // RX package split: origin in the upper word, objetive in the lower word
  localparam int RxWidth      = 64;
  localparam int RxFieldWidth = 32;
  localparam int OriginLsb    = 32;
  localparam int ObjetiveLsb  = 0;

  // TX result word: {zero pad, bestError, genCount, bestIndividual}, LSB first
  localparam int TxWidth         = 64;
  localparam int TxIndividualLsb = 0;

  function automatic int tx_gen_lsb(input int ind_w);
    return TxIndividualLsb + ind_w;
  endfunction

  function automatic int tx_err_lsb(input int ind_w, input int gen_w);
    return TxIndividualLsb + ind_w + gen_w;
  endfunction

  function automatic int tx_pad_width(input int err_w, input int gen_w, input int ind_w);
    return TxWidth - err_w - gen_w - ind_w;
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Registers the input once and flags a 0->1 transition for one clock.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign pulse_o = sig_i & ~prev_q;

endmodule

// File: rtl/ga_run_controller.sv
// One GA run per RX package: pop, hold GA in reset, count generations, report. Final report
// waits for TX idle; `GA_PERIODIC_REPORT_EN adds best-effort snapshots every 2**ReportShift gens.
module ga_run_controller
  import ga_ctrl_pkg::*;
#(
  parameter int                         ImageWidth      = 8,
  parameter int                         ImageHeight     = 4,
  parameter int                         ErrorWidth      = $clog2(ImageWidth * ImageHeight),
  parameter int                         IndividualWidth = 32,
  parameter int                         GenCounterWidth = 16,
  parameter logic [GenCounterWidth-1:0] MaxGenerations  = {GenCounterWidth{1'b1}},
  parameter int                         ResetCycles     = 2,
  parameter int                         ReportShift     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [RxWidth-1:0]                 rxData,
  input  logic                               rxVoid,
  output logic                               rxPull,
  output logic [ImageWidth*ImageHeight-1:0]  origin,
  output logic [ImageWidth*ImageHeight-1:0]  objetive,
  output logic                               gaRst,
  input  logic                               gaCycle,
  input  logic [ErrorWidth-1:0]              bestError,
  input  logic [IndividualWidth-1:0]         bestIndividual,
  output logic [TxWidth-1:0]                 txData,
  output logic                               txStart,
  input  logic                               txBusy,
  output logic                               finish,
  output logic                               timeout,
  output logic [GenCounterWidth-1:0]         genCount
);

  localparam int Pixels     = ImageWidth * ImageHeight;
  localparam int CntWidth   = $clog2(ResetCycles + 1);
  localparam int TxGenLsb   = tx_gen_lsb(IndividualWidth);
  localparam int TxErrLsb   = tx_err_lsb(IndividualWidth, GenCounterWidth);
  localparam int TxPadWidth = tx_pad_width(ErrorWidth, GenCounterWidth, IndividualWidth);

  if (TxPadWidth < 0) begin : g_bad_tx_width
    $error("ga_run_controller: txData fields exceed 64 bits");
  end
  if (Pixels > RxFieldWidth) begin : g_bad_image
    $error("ga_run_controller: image does not fit a 32-bit package field");
  end
  if (ResetCycles < 1) begin : g_bad_reset_cycles
    $error("ga_run_controller: ResetCycles must be at least 1");
  end
  if (ReportShift < 1 || ReportShift > GenCounterWidth) begin : g_bad_report_shift
    $error("ga_run_controller: ReportShift out of range");
  end

  function automatic logic [TxWidth-1:0] pack_tx(
    input logic [ErrorWidth-1:0]      err,
    input logic [GenCounterWidth-1:0] gen,
    input logic [IndividualWidth-1:0] ind
  );
    logic [TxWidth-1:0] w;
    w = '0;
    w[TxIndividualLsb +: IndividualWidth] = ind;
    w[TxGenLsb +: GenCounterWidth]        = gen;
    w[TxErrLsb +: ErrorWidth]             = err;
    return w;
  endfunction

  ga_state_e                state_q, state_d;
  logic [Pixels-1:0]        origin_q, origin_d;
  logic [Pixels-1:0]        objetive_q, objetive_d;
  logic [TxWidth-1:0]       tx_data_q, tx_data_d;
  logic                     tx_start_q, tx_start_d;
  logic                     finish_q, finish_d;
  logic                     timeout_q, timeout_d;
  logic [GenCounterWidth-1:0] gen_q, gen_d;
  logic [GenCounterWidth-1:0] gen_inc;
  logic [CntWidth-1:0]      rst_cnt_q, rst_cnt_d;
  logic [ErrorWidth-1:0]    res_err_q, res_err_d;
  logic [IndividualWidth-1:0] res_ind_q, res_ind_d;
  logic                     gen_evt;
  logic                     rx_pull;
  logic                     ga_rst;

  rising_edge_detect u_gen_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (gaCycle),
    .pulse_o (gen_evt)
  );

  assign gen_inc = gen_q + GenCounterWidth'(1);

  always_comb begin
    state_d    = state_q;
    origin_d   = origin_q;
    objetive_d = objetive_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    finish_d   = finish_q;
    timeout_d  = timeout_q;
    gen_d      = gen_q;
    rst_cnt_d  = rst_cnt_q;
    res_err_d  = res_err_q;
    res_ind_d  = res_ind_q;
    rx_pull    = 1'b0;
    ga_rst     = 1'b1;

    case (state_q)
      IDLE: begin
        if (!rxVoid) begin
          rx_pull    = 1'b1;
          origin_d   = rxData[OriginLsb +: Pixels];
          objetive_d = rxData[ObjetiveLsb +: Pixels];
          finish_d   = 1'b0;
          timeout_d  = 1'b0;
          gen_d      = '0;
          rst_cnt_d  = CntWidth'(ResetCycles);
          state_d    = GARST;
        end
      end

      GARST: begin
        rst_cnt_d = rst_cnt_q - CntWidth'(1);
        if (rst_cnt_q == CntWidth'(1)) begin
          state_d = RUN;
        end
      end

      RUN: begin
        ga_rst = 1'b0;
        if (gen_evt) begin
          if (bestError == '0) begin
            finish_d  = 1'b1;
            res_err_d = bestError;
            res_ind_d = bestIndividual;
            state_d   = REPORT;
          end else if (gen_q == MaxGenerations) begin
            finish_d  = 1'b1;
            timeout_d = 1'b1;
            res_err_d = bestError;
            res_ind_d = bestIndividual;
            state_d   = REPORT;
          end else begin
            gen_d = gen_inc;
`ifdef GA_PERIODIC_REPORT_EN
            if (gen_inc[ReportShift-1:0] == '0 && !txBusy) begin
              tx_data_d  = pack_tx(bestError, gen_inc, bestIndividual);
              tx_start_d = 1'b1;
            end
`endif
          end
        end
      end

      // Result is captured at the final event: the GA is held in reset from here on,
      // so its live outputs are no longer meaningful.
      REPORT: begin
        if (!txBusy) begin
          tx_data_d  = pack_tx(res_err_q, gen_q, res_ind_q);
          tx_start_d = 1'b1;
          state_d    = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (txBusy) begin
          state_d = WAIT_TX;
        end
      end

      WAIT_TX: begin
        if (!txBusy) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      origin_q   <= '0;
      objetive_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      finish_q   <= 1'b0;
      timeout_q  <= 1'b0;
      gen_q      <= '0;
      rst_cnt_q  <= '0;
      res_err_q  <= '0;
      res_ind_q  <= '0;
    end else begin
      state_q    <= state_d;
      origin_q   <= origin_d;
      objetive_q <= objetive_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      finish_q   <= finish_d;
      timeout_q  <= timeout_d;
      gen_q      <= gen_d;
      rst_cnt_q  <= rst_cnt_d;
      res_err_q  <= res_err_d;
      res_ind_q  <= res_ind_d;
    end
  end

  // Pop strobe is combinational so it lines up with the queue head being latched.
  assign rxPull   = rx_pull & ~rst;
  assign gaRst    = ga_rst | rst;
  assign origin   = origin_q;
  assign objetive = objetive_q;
  assign txData   = tx_data_q;
  assign txStart  = tx_start_q;
  assign finish   = finish_q;
  assign timeout  = timeout_q;
  assign genCount = gen_q;

endmodule

// File: tb/tb_ga_run_controller.sv
// Directed bench for ga_run_controller: default limit instance plus a MaxGenerations=4 instance.
module tb_ga_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] rxData;
  logic [31:0] bestIndividual;

  logic        rxVoid, gaCycle, txBusy;
  logic [4:0]  bestError;
  logic        rxPull, gaRst, txStart, finish, timeout;
  logic [31:0] origin, objetive;
  logic [63:0] txData;
  logic [15:0] genCount;

  logic        rxVoid_t, gaCycle_t, txBusy_t;
  logic [4:0]  bestError_t;
  logic        rxPull_t, gaRst_t, txStart_t, finish_t, timeout_t;
  logic [31:0] origin_t, objetive_t;
  logic [63:0] txData_t;
  logic [15:0] genCount_t;

  int total = 0;
  int bad   = 0;

  int          tx_cnt = 0, tx_cnt_t = 0, rx_cnt = 0;
  logic [63:0] tx_last = '0, tx_last_t = '0;

  ga_run_controller dut (
    .clk(clk), .rst(rst), .rxData(rxData), .rxVoid(rxVoid), .rxPull(rxPull),
    .origin(origin), .objetive(objetive), .gaRst(gaRst), .gaCycle(gaCycle),
    .bestError(bestError), .bestIndividual(bestIndividual), .txData(txData),
    .txStart(txStart), .txBusy(txBusy), .finish(finish), .timeout(timeout),
    .genCount(genCount)
  );

  ga_run_controller #(.MaxGenerations(16'd4)) dut_t (
    .clk(clk), .rst(rst), .rxData(rxData), .rxVoid(rxVoid_t), .rxPull(rxPull_t),
    .origin(origin_t), .objetive(objetive_t), .gaRst(gaRst_t), .gaCycle(gaCycle_t),
    .bestError(bestError_t), .bestIndividual(bestIndividual), .txData(txData_t),
    .txStart(txStart_t), .txBusy(txBusy_t), .finish(finish_t), .timeout(timeout_t),
    .genCount(genCount_t)
  );

  always @(negedge clk) begin
    if (txStart) begin
      tx_cnt++;
      tx_last = txData;
    end
    if (txStart_t) begin
      tx_cnt_t++;
      tx_last_t = txData_t;
    end
    if (rxPull) rx_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_a(input logic [4:0] err);
    bestError = err;
    gaCycle = 1'b1;
    tick();
    gaCycle = 1'b0;
    tick();
  endtask

  task automatic gen_t(input logic [4:0] err);
    bestError_t = err;
    gaCycle_t = 1'b1;
    tick();
    gaCycle_t = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxData = '0; bestIndividual = '0;
    rxVoid = 1'b1; gaCycle = 1'b0; txBusy = 1'b0; bestError = '0;
    rxVoid_t = 1'b1; gaCycle_t = 1'b0; txBusy_t = 1'b0; bestError_t = '0;
    tick();
    tick();
    total++;
    if (origin !== 32'h0 || objetive !== 32'h0) begin
      bad++; $display("FAIL reset_images got=%h/%h exp=0/0", origin, objetive);
    end
    total++;
    if (txData !== 64'h0) begin
      bad++; $display("FAIL reset_txdata got=%h exp=0", txData);
    end
    total++;
    if (genCount !== 16'h0 || genCount_t !== 16'h0) begin
      bad++; $display("FAIL reset_gencount got=%h/%h exp=0", genCount, genCount_t);
    end
    total++;
    if ({finish, timeout, txStart, rxPull} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {finish, timeout, txStart, rxPull});
    end
    total++;
    if (gaRst !== 1'b1 || gaRst_t !== 1'b1) begin
      bad++; $display("FAIL reset_garst got=%b%b exp=11", gaRst, gaRst_t);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int i;
    rxData = 64'hCAFEF00D_0BADBEEF;
    bestIndividual = 32'hDEADBEEF;
    rxVoid_t = 1'b0;
    tick();
    rxVoid_t = 1'b1;
    total++;
    if (origin_t !== 32'hCAFEF00D || objetive_t !== 32'h0BADBEEF) begin
      bad++; $display("FAIL to_latch got=%h/%h exp=cafef00d/0badbeef", origin_t, objetive_t);
    end
    for (i = 0; i < 10 && gaRst_t; i++) tick();
    repeat (4) gen_t(5'd7);
    total++;
    if (genCount_t !== 16'd4 || finish_t !== 1'b0) begin
      bad++; $display("FAIL to_count got=%0d/%b exp=4/0", genCount_t, finish_t);
    end
    bestError_t = 5'd7;
    gaCycle_t = 1'b1;
    tick();
    gaCycle_t = 1'b0;
    total++;
    if ({finish_t, timeout_t} !== 2'b11 || genCount_t !== 16'd4) begin
      bad++; $display("FAIL to_flags got=%b%b/%0d exp=11/4", finish_t, timeout_t, genCount_t);
    end
    for (i = 0; i < 20 && tx_cnt_t == 0; i++) tick();
    total++;
    if (tx_last_t !== 64'h0007_0004_DEADBEEF) begin
      bad++; $display("FAIL to_txdata got=%h exp=00070004deadbeef", tx_last_t);
    end
    txBusy_t = 1'b1;
    repeat (2) tick();
    txBusy_t = 1'b0;
    repeat (3) tick();
    total++;
    if (tx_cnt_t !== 1) begin
      bad++; $display("FAIL to_txstart_count got=%0d exp=1", tx_cnt_t);
    end
  endtask

  task automatic test_pop_and_garst();
    int hi;
    rxData = 64'h00103810_00387C38;
    rxVoid = 1'b0;
    #1;
    total++;
    if (rxPull !== 1'b1 || gaRst !== 1'b1) begin
      bad++; $display("FAIL pop_strobe got=%b/%b exp=1/1", rxPull, gaRst);
    end
    tick();
    rxVoid = 1'b1;
    #1;
    total++;
    if (rxPull !== 1'b0 || rx_cnt !== 1) begin
      bad++; $display("FAIL pop_single got=%b/%0d exp=0/1", rxPull, rx_cnt);
    end
    total++;
    if (origin !== 32'h00103810 || objetive !== 32'h00387C38) begin
      bad++; $display("FAIL pop_latch got=%h/%h exp=00103810/00387c38", origin, objetive);
    end
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (!gaRst) break;
      hi++;
      tick();
    end
    total++;
    if (hi !== 2 || gaRst !== 1'b0) begin
      bad++; $display("FAIL garst_window got=%0d/%b exp=2/0", hi, gaRst);
    end
  endtask

  task automatic test_finish();
    int base, i;
    bestIndividual = 32'hDEADBEEF;
    repeat (5) gen_a(5'd3);
    total++;
    if (genCount !== 16'd5 || finish !== 1'b0) begin
      bad++; $display("FAIL fin_count got=%0d/%b exp=5/0", genCount, finish);
    end
    base = tx_cnt;
    bestError = 5'd0;
    gaCycle = 1'b1;
    tick();
    gaCycle = 1'b0;
    total++;
    if ({finish, timeout} !== 2'b10 || gaRst !== 1'b1 || genCount !== 16'd5) begin
      bad++; $display("FAIL fin_flags got=%b%b/%b/%0d exp=10/1/5", finish, timeout, gaRst, genCount);
    end
    for (i = 0; i < 20 && tx_cnt == base; i++) tick();
    total++;
    if (tx_last !== 64'h0000_0005_DEADBEEF) begin
      bad++; $display("FAIL fin_txdata got=%h exp=00000005deadbeef", tx_last);
    end
    txBusy = 1'b1;
    repeat (2) tick();
    txBusy = 1'b0;
    repeat (2) tick();
    total++;
    if (tx_cnt !== base + 1 || finish !== 1'b1) begin
      bad++; $display("FAIL fin_single_tx got=%0d/%b exp=%0d/1", tx_cnt, finish, base + 1);
    end
  endtask

  task automatic test_busy_and_queue();
    int base_rx, base_tx, i;
    base_rx = rx_cnt;
    rxData = 64'hA5A5A5A5_0F0F0F0F;
    rxVoid = 1'b0;
    tick();
    rxData = 64'h11111111_22222222;
    total++;
    if ({finish, timeout} !== 2'b00 || genCount !== 16'd0 || origin !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL q_pop_clear got=%b%b/%0d/%h exp=00/0/a5a5a5a5", finish, timeout, genCount, origin);
    end
    for (i = 0; i < 10 && gaRst; i++) tick();
    bestIndividual = 32'h12345678;
    gen_a(5'd5);
    gen_a(5'd5);
    txBusy = 1'b1;
    bestError = 5'd0;
    gaCycle = 1'b1;
    tick();
    gaCycle = 1'b0;
    base_tx = tx_cnt;
    repeat (6) tick();
    total++;
    if (tx_cnt !== base_tx || finish !== 1'b1) begin
      bad++; $display("FAIL busy_withheld got=%0d/%b exp=%0d/1", tx_cnt, finish, base_tx);
    end
    txBusy = 1'b0;
    for (i = 0; i < 20 && tx_cnt == base_tx; i++) tick();
    total++;
    if (tx_last !== 64'h0000_0002_12345678) begin
      bad++; $display("FAIL busy_txdata got=%h exp=0000000212345678", tx_last);
    end
    repeat (4) tick();
    total++;
    if (rx_cnt !== base_rx + 1) begin
      bad++; $display("FAIL q_held got=%0d exp=%0d", rx_cnt, base_rx + 1);
    end
    txBusy = 1'b1;
    repeat (2) tick();
    txBusy = 1'b0;
    for (i = 0; i < 3 && rx_cnt == base_rx + 1; i++) tick();
    rxVoid = 1'b1;
    total++;
    if (rx_cnt !== base_rx + 2 || tx_cnt !== base_tx + 1) begin
      bad++; $display("FAIL q_pop_after_tx got=%0d/%0d exp=%0d/%0d", rx_cnt, tx_cnt, base_rx + 2, base_tx + 1);
    end
    total++;
    if (finish !== 1'b0 || origin !== 32'h11111111) begin
      bad++; $display("FAIL q_second_latch got=%b/%h exp=0/11111111", finish, origin);
    end
  endtask

  task automatic test_reset_midrun();
    int base, i;
    for (i = 0; i < 10 && gaRst; i++) tick();
    repeat (3) gen_a(5'd2);
    total++;
    if (genCount !== 16'd3) begin
      bad++; $display("FAIL mid_count got=%0d exp=3", genCount);
    end
    base = tx_cnt;
    rst = 1'b1;
    tick();
    total++;
    if (genCount !== 16'd0 || origin !== 32'h0 || txData !== 64'h0 || {finish, txStart} !== 2'b00 || gaRst !== 1'b1) begin
      bad++; $display("FAIL mid_reset got=%0d/%h/%h/%b%b/%b exp=0/0/0/00/1",
                      genCount, origin, txData, finish, txStart, gaRst);
    end
    rst = 1'b0;
    repeat (5) tick();
    total++;
    if (tx_cnt !== base || gaRst !== 1'b1) begin
      bad++; $display("FAIL mid_no_report got=%0d/%b exp=%0d/1", tx_cnt, gaRst, base);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_pop_and_garst();
    test_finish();
    test_busy_and_queue();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
